// File: rtl/contador_pkg.sv
// Shared definitions for the parametrised counter: modo encodings used by the RTL
// and by the driver/checker/scoreboard that sit around it.
package contador_pkg;

   localparam logic [1:0] MODO_UP      = 2'b00;
   localparam logic [1:0] MODO_DN      = 2'b01;
   localparam logic [1:0] MODO_DN_STEP = 2'b10;
   localparam logic [1:0] MODO_LOAD    = 2'b11;

endpackage

// File: rtl/contador_nxt.sv
// Combinational next-count and wrap generator for contador_param.
// Build option: define SATURATE_EN to clamp at the range limits instead of wrapping.
module contador_nxt
   import contador_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 3
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic [1:0]       i_modo,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_nxt,
   output logic             o_wrap
);

   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

   logic [WIDTH:0] w_ext;
   logic [WIDTH:0] w_sum;

   // Extended arithmetic: the top bit is the carry/borrow out that marks a wrap.
   always_comb begin
      w_ext = {1'b0, i_q};
      w_sum = w_ext;
      case (i_modo)
         MODO_UP:      w_sum = w_ext + ONE_EXT;
         MODO_DN:      w_sum = w_ext - ONE_EXT;
         MODO_DN_STEP: w_sum = w_ext - STEP_EXT;
         MODO_LOAD:    w_sum = {1'b0, i_d};
         default:      w_sum = w_ext;
      endcase
   end

   // Select the wrapped (or clamped) next value.
   always_comb begin
      o_wrap = w_sum[WIDTH];
`ifdef SATURATE_EN
      if (w_sum[WIDTH]) begin
         if (i_modo == MODO_UP) begin
            o_nxt = {WIDTH{1'b1}};
         end else begin
            o_nxt = {WIDTH{1'b0}};
         end
      end else begin
         o_nxt = w_sum[WIDTH-1:0];
      end
`else
      o_nxt = w_sum[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down/step/load counter with cascade carry-in, look-ahead tc,
// registered rco pulse and sticky ovf. Build option: SATURATE_EN (see contador_nxt).
module contador_param
   import contador_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cin,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             rco,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] r_q;
   logic             r_rco;
   logic             r_ovf;
   logic [WIDTH-1:0] w_nxt;
   logic             w_wrap;
   logic             w_advance;
   logic             w_load;

   contador_nxt #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_nxt (
      .i_q    (r_q),
      .i_modo (modo),
      .i_d    (D),
      .o_nxt  (w_nxt),
      .o_wrap (w_wrap)
   );

   // Loads ignore cin so a chained stage can always be preset.
   assign w_advance = enable & cin & (modo != MODO_LOAD);
   assign w_load    = enable & (modo == MODO_LOAD);
   assign tc        = w_advance & w_wrap;

   // Count state, ripple-carry pulse and sticky overflow; reset beats everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q   <= {WIDTH{1'b0}};
         r_rco <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_load) begin
         r_q   <= D;
         r_rco <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_advance) begin
         r_q   <= w_nxt;
         r_rco <= w_wrap;
         r_ovf <= r_ovf | w_wrap;
      end else begin
         r_q   <= r_q;
         r_rco <= 1'b0;
         r_ovf <= r_ovf;
      end
   end

   assign Q   = r_q;
   assign rco = r_rco;
   assign ovf = r_ovf;

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param: directed scenarios, a randomized run
// against an arithmetic reference model, and a two-stage 4-bit cascade.
module tb_contador_param;

   localparam int      W    = 32;
   localparam int      STP  = 3;
   localparam longint  MODV = 64'h1_0000_0000;

   logic          clk = 1'b0;
   logic          reset, enable, cin;
   logic [1:0]    modo;
   logic [W-1:0]  d;
   logic [W-1:0]  q;
   logic          rco, tc, ovf;

   logic          c_enable;
   logic [1:0]    c_modo;
   logic [7:0]    c_d;
   logic [3:0]    c_q_lo, c_q_hi;
   logic          c_rco_lo, c_rco_hi, c_tc_lo, c_tc_hi, c_ovf_lo, c_ovf_hi;

   int n_checks = 0;
   int n_pass   = 0;

   longint m_q;
   bit     m_rco, m_ovf, m_known;

   always #5 clk = ~clk;

   contador_param #(.WIDTH(W), .STEP(STP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .cin(cin), .modo(modo),
      .D(d), .Q(q), .rco(rco), .tc(tc), .ovf(ovf)
   );

   contador_param #(.WIDTH(4), .STEP(STP)) u_lo (
      .clk(clk), .reset(reset), .enable(c_enable), .cin(1'b1), .modo(c_modo),
      .D(c_d[3:0]), .Q(c_q_lo), .rco(c_rco_lo), .tc(c_tc_lo), .ovf(c_ovf_lo)
   );

   contador_param #(.WIDTH(4), .STEP(STP)) u_hi (
      .clk(clk), .reset(reset), .enable(c_enable), .cin(c_tc_lo), .modo(c_modo),
      .D(c_d[7:4]), .Q(c_q_hi), .rco(c_rco_hi), .tc(c_tc_hi), .ovf(c_ovf_hi)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Attempted result of a count in plain integer arithmetic; wrap = left the range.
   task automatic model_try(input logic [1:0] md, output longint nq, output bit wrap);
      longint t;
      case (md)
         2'b00:   t = m_q + 1;
         2'b01:   t = m_q - 1;
         2'b10:   t = m_q - STP;
         default: t = m_q;
      endcase
      wrap = (t < 0) || (t >= MODV);
`ifdef SATURATE_EN
      nq = (t < 0) ? 0 : ((t >= MODV) ? MODV - 1 : t);
`else
      nq = ((t % MODV) + MODV) % MODV;
`endif
   endtask

   // One clock: drive, check look-ahead tc, clock, advance model, check outputs.
   task automatic cyc(input bit r, input bit e, input bit c, input logic [1:0] md, input logic [W-1:0] dv);
      longint nq;
      bit     wrap, adv;
      reset = r; enable = e; cin = c; modo = md; d = dv;
      #1;
      adv = e && c && (md != 2'b11);
      if (m_known) begin
         model_try(md, nq, wrap);
         check("tc", tc, adv && wrap);
      end else begin
         nq = 0; wrap = 1'b0;
      end
      @(posedge clk); #1;
      if (r) begin
         m_q = 0; m_rco = 0; m_ovf = 0; m_known = 1;
      end else if (e && md == 2'b11) begin
         m_q = dv; m_rco = 0; m_ovf = 0;
      end else if (adv && m_known) begin
         m_q = nq; m_rco = wrap; m_ovf = m_ovf | wrap;
      end else begin
         m_rco = 0;
      end
      if (m_known) begin
         check("q",   q,   m_q);
         check("rco", rco, m_rco);
         check("ovf", ovf, m_ovf);
      end
   endtask

   initial begin
      logic [W-1:0] rd;
      logic [W-1:0] edges [4];
      m_q = 0; m_rco = 0; m_ovf = 0; m_known = 0;
      c_enable = 1'b0; c_modo = 2'b00; c_d = 8'h00;
      edges[0] = 32'hFFFF_FFFE; edges[1] = 32'h0000_0000;
      edges[2] = 32'h0000_0002; edges[3] = 32'hFFFF_FFFF;
      reset = 1'b1; enable = 1'b1; cin = 1'b1; modo = 2'b00; d = '0;
      @(negedge clk);

      // Reset held two cycles while enabled in up mode.
      cyc(1, 1, 1, 2'b00, '0);
      cyc(1, 1, 1, 2'b00, '0);
      check("reset_q", q, 32'h0);

      // Load near the top, count up through the wrap.
      cyc(0, 1, 1, 2'b11, 32'hFFFF_FFFE);
      check("load_q", q, 32'hFFFF_FFFE);
      cyc(0, 1, 1, 2'b00, '0);
      check("top_q", q, 32'hFFFF_FFFF);
      cyc(0, 1, 1, 2'b00, '0);
`ifdef SATURATE_EN
      check("wrap_up_q", q, 32'hFFFF_FFFF);
`else
      check("wrap_up_q", q, 32'h0);
`endif
      check("wrap_up_rco", rco, 1'b1);
      cyc(0, 1, 1, 2'b00, '0);
      check("ovf_sticky", ovf, 1'b1);
      check("rco_pulse", rco, 1'b0);

      // Step-down borrow from 5.
      cyc(0, 1, 1, 2'b11, 32'd5);
      cyc(0, 1, 1, 2'b10, '0);
      check("step_q", q, 32'd2);
      cyc(0, 1, 1, 2'b10, '0);
`ifdef SATURATE_EN
      check("step_wrap_q", q, 32'h0);
`else
      check("step_wrap_q", q, 32'hFFFF_FFFF);
`endif
      check("step_wrap_rco", rco, 1'b1);

      // Hold on enable low, then on cin low, then resume.
      cyc(0, 1, 1, 2'b11, 32'd100);
      cyc(0, 1, 1, 2'b00, '0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'b00, '0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 2'b01, '0);
      check("hold_q", q, 32'd101);
      cyc(0, 1, 1, 2'b00, '0);
      check("resume_q", q, 32'd102);
      cyc(0, 1, 0, 2'b11, 32'd9);
      check("load_ignores_cin", q, 32'd9);

      // Reset colliding with a load, and with a wrap while ovf is set.
      cyc(1, 1, 1, 2'b11, 32'd7);
      check("rst_vs_load_q", q, 32'h0);
      cyc(0, 1, 1, 2'b01, '0);
      check("dn_wrap_ovf", ovf, 1'b1);
      cyc(0, 1, 1, 2'b11, 32'hFFFF_FFFF);
      cyc(0, 1, 1, 2'b00, '0);
      cyc(0, 1, 1, 2'b01, '0);
      cyc(1, 1, 1, 2'b00, '0);
      check("rst_vs_wrap_q", q, 32'h0);
      check("rst_vs_wrap_rco", rco, 1'b0);
      check("rst_vs_wrap_ovf", ovf, 1'b0);

      // Randomized run against the reference model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3, 0) == 0) rd = edges[$urandom_range(3, 0)];
         else rd = $urandom;
         cyc(($urandom_range(49, 0) == 0), ($urandom_range(7, 0) != 0),
             ($urandom_range(7, 0) != 0), 2'($urandom_range(3, 0)), rd);
      end

      // Two 4-bit stages chained through tc, counting up from 8'h0E.
      reset = 1'b0; enable = 1'b0;
      c_enable = 1'b1; c_modo = 2'b11; c_d = 8'h0E;
      @(posedge clk); #1;
      check("cas_load", {c_q_hi, c_q_lo}, 8'h0E);
      c_modo = 2'b00;
      @(posedge clk); #1;
      check("cas_0f", {c_q_hi, c_q_lo}, 8'h0F);
      check("cas_tc_lo", c_tc_lo, 1'b1);
      @(posedge clk); #1;
`ifdef SATURATE_EN
      check("cas_10", {c_q_hi, c_q_lo}, 8'h1F);
`else
      check("cas_10", {c_q_hi, c_q_lo}, 8'h10);
`endif
      check("cas_rco_lo", c_rco_lo, 1'b1);
      check("cas_rco_hi", c_rco_hi, 1'b0);
      @(posedge clk); #1;
`ifndef SATURATE_EN
      check("cas_11", {c_q_hi, c_q_lo}, 8'h11);
`endif
      check("cas_rco_lo_pulse", c_rco_lo, 1'b0);
      c_enable = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
